// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 register file, two operand read ports plus a debug read port, $0 hardwired to zero
// Optional macro RF_BYPASS_EN: forward same-cycle writeback data to the operand read ports.
`timescale 1ns/1ps
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DATA_WIDTH-1:0] stored_a;
  logic [DATA_WIDTH-1:0] stored_b;
  logic                  wr_live;

  // Writes to $0 are dropped so entry 0 holds the zero it got at reset.
  assign wr_live = wr_en && !rst && (wr_addr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign stored_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
  assign stored_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];
  assign dbg_data = (dbg_addr  == '0) ? '0 : regs[dbg_addr];

`ifdef RF_BYPASS_EN
  // wr_live already excludes $0 and reset cycles, so the forward never breaks those rules.
  assign rd_data_a = (wr_live && (rd_addr_a == wr_addr)) ? wr_data : stored_a;
  assign rd_data_b = (wr_live && (rd_addr_b == wr_addr)) ? wr_data : stored_b;
`else
  assign rd_data_a = stored_a;
  assign rd_data_b = stored_b;
`endif

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - randomized and directed bench for reg_file against an array model
`timescale 1ns/1ps
module tb_reg_file;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr_a, rd_addr_b, wr_addr, dbg_addr;
  logic [31:0] rd_data_a, rd_data_b, wr_data, dbg_data;
  logic        wr_en;

  int total = 0;
  int bad   = 0;
  bit sb_en = 1'b0;
  logic [31:0] mdl [32];

  always #5 clk = ~clk;

  reg_file dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] expect_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (BYP && wr_en && !rst && wr_addr != 5'd0 && wr_addr == a) return wr_data;
    return mdl[a];
  endfunction

  // Reference: an array that clears on reset and accepts nonzero-address writes.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl[i] <= 32'd0;
    end else if (wr_en && wr_addr != 5'd0) begin
      mdl[wr_addr] <= wr_data;
    end
  end

  always @(negedge clk) begin
    if (sb_en) begin
      chk("sb_rd_a", rd_data_a, expect_rd(rd_addr_a));
      chk("sb_rd_b", rd_data_b, expect_rd(rd_addr_b));
      chk("sb_dbg",  dbg_data,  mdl[dbg_addr]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0; dbg_addr = '0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    step();
    sb_en = 1'b1;
    step();
    rst = 1'b0;

    // reset discards a concurrent write and clears prior state
    wr(5'd5, 32'hDEADBEEF);
    rd_addr_a = 5'd5;
    @(negedge clk);
    chk("pre_reset_r5", rd_data_a, 32'hDEADBEEF);
    rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h1234;
    step();
    rst = 1'b0; wr_en = 1'b0;
    rd_addr_a = 5'd5; rd_addr_b = 5'd6;
    @(negedge clk);
    chk("reset_r5", rd_data_a, 32'd0);
    chk("reset_r6", rd_data_b, 32'd0);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      @(negedge clk);
      chk("reset_dbg", dbg_data, 32'd0);
      step();
    end

    // basic write and read
    wr(5'd1, 32'h00000005);
    wr(5'd2, 32'hFFFFFFFB);
    rd_addr_a = 5'd1; rd_addr_b = 5'd2;
    @(negedge clk);
    chk("basic_a", rd_data_a, 32'h00000005);
    chk("basic_b", rd_data_b, 32'hFFFFFFFB);
    chk("basic_sum", rd_data_a + rd_data_b, 32'd0);
    step();

    // $0 ignores writes
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr_a = 5'd0; dbg_addr = 5'd0;
    @(negedge clk);
    chk("zero_same", rd_data_a, 32'd0);
    step();
    wr_en = 1'b0;
    @(negedge clk);
    chk("zero_next", rd_data_a, 32'd0);
    chk("zero_dbg", dbg_data, 32'd0);
    step();

    // same-cycle read of the written register
    wr(5'd7, 32'h11111111);
    rd_addr_a = 5'd7; dbg_addr = 5'd7;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h22222222;
    @(negedge clk);
    chk("rw_same_a", rd_data_a, BYP ? 32'h22222222 : 32'h11111111);
    chk("rw_same_dbg", dbg_data, 32'h11111111);
    step();
    wr_en = 1'b0;
    @(negedge clk);
    chk("rw_next_a", rd_data_a, 32'h22222222);
    chk("rw_next_dbg", dbg_data, 32'h22222222);
    step();

    // dual-port same address, then wr_en gating
    wr(5'd31, 32'hA5A5A5A5);
    rd_addr_a = 5'd31; rd_addr_b = 5'd31;
    @(negedge clk);
    chk("dual_a", rd_data_a, 32'hA5A5A5A5);
    chk("dual_b", rd_data_b, 32'hA5A5A5A5);
    wr_en = 1'b0; wr_addr = 5'd31; wr_data = 32'd0;
    repeat (3) step();
    @(negedge clk);
    chk("gate_a", rd_data_a, 32'hA5A5A5A5);
    chk("gate_b", rd_data_b, 32'hA5A5A5A5);
    step();

    // full sweep
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h01010101);
    for (int i = 0; i < 32; i++) begin
      v = 32'(i) * 32'h01010101;
      rd_addr_a = 5'(i); rd_addr_b = 5'(i); dbg_addr = 5'(i);
      @(negedge clk);
      chk("sweep_a", rd_data_a, v);
      chk("sweep_b", rd_data_b, v);
      chk("sweep_dbg", dbg_data, v);
      step();
    end

    // randomized traffic with frequent address collisions and rare resets
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 63) == 0);
      wr_en     = $urandom_range(0, 1) != 0;
      wr_addr   = 5'($urandom);
      wr_data   = $urandom;
      rd_addr_a = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom);
      rd_addr_b = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom);
      dbg_addr  = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom);
      step();
    end
    rst = 1'b0; wr_en = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
